exp_seq: RTL

Sequential square-and-multiply unit that computes the unreduced power g^x as a 64-bit value for the Diffie-Hellman datapath. It sits directly upstream of the R1/R2 modular-reduction stage: its `exp` and `st` outputs drive that stage's `exp` and `st` inputs. `st` is held high while `exp` is stable, because the reduction stage is a 3-deep pipeline that clears itself whenever `st` is low. Overflow beyond 64 bits is flagged rather than silently wrapped.

---
 rtl/exp_seq.sv | 93 +++++++++
 1 files changed

// File: rtl/exp_seq.sv
// Square-and-multiply g^x to a saturating 64-bit result; one exponent bit per cycle, 1+max(1,bitlen(x)) cycles start-to-st.
// No backpressure: start is ignored while busy, and the result is held with st=1 until the next start or reset.
module exp_seq #(
    parameter int XW = 32,
    parameter int GW = 32
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [GW-1:0] i_g,
    input  logic [XW-1:0] i_x,
    input  logic          i_start,
    output logic [63:0]   o_exp,
    output logic          o_st,
    output logic          o_busy,
    output logic          o_ovf
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [63:0]   r_acc;
    logic [63:0]   r_base;
    logic [XW-1:0] r_e;
    logic          r_big;
    logic          r_ovf;

    logic [127:0]  w_pa;
    logic [127:0]  w_pb;
    logic [63:0]   w_acc_n;
    logic          w_ovf_n;
    logic          w_big_n;
    logic [XW-1:0] w_e_n;

    assign w_pa    = {64'd0, r_acc} * {64'd0, r_base};
    assign w_pb    = {64'd0, r_base} * {64'd0, r_base};
    assign w_acc_n = r_e[0] ? w_pa[63:0] : r_acc;
    // r_big means r_base is truncated, so multiplying it into a nonzero acc must overflow
    assign w_ovf_n = r_ovf | (r_e[0] & ((w_pa[127:64] != 64'd0) | (r_big & (r_acc != 64'd0))));
    assign w_big_n = r_big | (w_pb[127:64] != 64'd0);
    assign w_e_n   = r_e >> 1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_acc   <= 64'd0;
            r_base  <= 64'd0;
            r_e     <= '0;
            r_big   <= 1'b0;
            r_ovf   <= 1'b0;
            o_exp   <= 64'd0;
            o_st    <= 1'b0;
            o_busy  <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state <= S_RUN;
                        r_acc   <= 64'd1;
                        r_base  <= 64'(i_g);
                        r_e     <= i_x;
                        r_big   <= 1'b0;
                        r_ovf   <= 1'b0;
                        o_st    <= 1'b0;
                        o_busy  <= 1'b1;
                        o_ovf   <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_acc  <= w_acc_n;
                    r_base <= w_pb[63:0];
                    r_big  <= w_big_n;
                    r_ovf  <= w_ovf_n;
                    r_e    <= w_e_n;
                    // Publish from next-state values so exp/ovf land on the same edge st rises
                    if (w_e_n == '0) begin
                        r_state <= S_DONE;
                        o_st    <= 1'b1;
                        o_busy  <= 1'b0;
                        o_exp   <= w_ovf_n ? 64'hFFFF_FFFF_FFFF_FFFF : w_acc_n;
                        o_ovf   <= w_ovf_n;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
